// File: rtl/n64_audio_i2s_tx_if.sv
// n64_audio_i2s_tx_if: parallel stereo sample bus from the APU deserializer.
// One-cycle valid strobe qualifies both 16-bit two's complement samples.
interface n64_audio_i2s_tx_if;
  logic [15:0] pdata_left;
  logic [15:0] pdata_right;
  logic        pdata_valid;

  modport master (
    output pdata_left,
    output pdata_right,
    output pdata_valid
  );

  modport slave (
    input pdata_left,
    input pdata_right,
    input pdata_valid
  );
endinterface

// File: rtl/n64_audio_i2s_tx.sv
// n64_audio_i2s_tx: double-buffered parallel-to-I2S serializer, MCLK = 256 Fs.
// Define N64_AUDIO_I2S_TX_24BIT_EN for 24-bit words ({sample, 8'h00}).
module n64_audio_i2s_tx #(
  parameter logic MUTE_ON_UNDERRUN = 1'b0
) (
  input  logic              MCLK_i,
  input  logic              nRST_i,
  input  logic              EN_i,
  n64_audio_i2s_tx_if.slave pdata,
  output logic              SCLK_o,
  output logic              LRCLK_o,
  output logic              SDATA_o,
  output logic              UNDERRUN_o,
  output logic              OVERRUN_o
);

`ifdef N64_AUDIO_I2S_TX_24BIT_EN
  localparam int W = 24;
`else
  localparam int W = 16;
`endif
  localparam int IW = $clog2(W);

  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        load;
  logic        pending;
  logic [15:0] hold_l;
  logic [15:0] hold_r;
  logic [15:0] frame_l;
  logic [15:0] frame_r;
  logic [W-1:0] word_l;
  logic [W-1:0] word_r;
  logic [5:0]  slot;
  logic [5:0]  idx_l;
  logic [5:0]  idx_r;
  logic        in_l;
  logic        in_r;
  logic        sd_bit;

  assign cnt_nxt = cnt + 8'd1;
  assign load    = (cnt == 8'hFF);
  assign slot    = cnt_nxt[7:2];

`ifdef N64_AUDIO_I2S_TX_24BIT_EN
  assign word_l = {frame_l, 8'h00};
  assign word_r = {frame_r, 8'h00};
`else
  assign word_l = frame_l;
  assign word_r = frame_r;
`endif

  assign idx_l = 6'(W) - slot;
  assign idx_r = 6'(W + 32) - slot;
  assign in_l  = (slot >= 6'd1) && (slot <= 6'(W));
  assign in_r  = (slot >= 6'd33) && (slot <= 6'(W + 32));

  // Serial bit for the slot the counter is about to enter.
  always_comb begin
    sd_bit = 1'b0;
    unique case (1'b1)
      in_l:    sd_bit = word_l[idx_l[IW-1:0]];
      in_r:    sd_bit = word_r[idx_r[IW-1:0]];
      default: sd_bit = 1'b0;
    endcase
  end

  // Free-running frame counter; one wrap per output sample.
  always_ff @(posedge MCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // Hold buffer capture and frame load at the frame boundary.
  always_ff @(posedge MCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      pending <= 1'b0;
      hold_l  <= 16'd0;
      hold_r  <= 16'd0;
      frame_l <= 16'd0;
      frame_r <= 16'd0;
    end else if (load) begin
      pending <= 1'b0;
      if (pdata.pdata_valid) begin
        frame_l <= pdata.pdata_left;
        frame_r <= pdata.pdata_right;
      end else if (pending) begin
        frame_l <= hold_l;
        frame_r <= hold_r;
      end else if (MUTE_ON_UNDERRUN) begin
        frame_l <= 16'd0;
        frame_r <= 16'd0;
      end
    end else if (pdata.pdata_valid) begin
      hold_l  <= pdata.pdata_left;
      hold_r  <= pdata.pdata_right;
      pending <= 1'b1;
    end
  end

  // Status pulses, registered one cycle after the triggering event.
  always_ff @(posedge MCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      UNDERRUN_o <= 1'b0;
      OVERRUN_o  <= 1'b0;
    end else begin
      UNDERRUN_o <= load & ~pdata.pdata_valid & ~pending;
      OVERRUN_o  <= ~load & pdata.pdata_valid & pending;
    end
  end

  // I2S pins from the next count so all three move on one edge.
  always_ff @(posedge MCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      SCLK_o  <= 1'b0;
      LRCLK_o <= 1'b0;
      SDATA_o <= 1'b0;
    end else begin
      SCLK_o  <= cnt_nxt[1];
      LRCLK_o <= cnt_nxt[7];
      if (cnt_nxt[1:0] == 2'b00) begin
        SDATA_o <= EN_i & sd_bit;
      end
    end
  end

endmodule
